chacha20_cfg_loader: RTL and testbench
======================================

CHACHA20_CFG_LOADER -- requirements
Module: chacha20_cfg_loader

Interface
REQ-001 SHALL have parameter AXI_IDWIDTH, default 4, width of the AXI ID fields.
REQ-002 SHALL have parameter CFG_ID, default 0, the constant value driven on m_axi_awid.
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 aclk  in  1  clock; all logic on its rising edge.
REQ-005 areset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to program a new key, counter and nonce.
REQ-007 key  in  256  key words k0..k7, with k_i = key[32i+31:32i].
REQ-008 counter  in  32  initial block counter.
REQ-009 nonce  in  96  nonce words n0..n2, with n_i = nonce[32i+31:32i].
REQ-010 outdate_key  in  1  keystream-exhausted flag from chacha20.
REQ-011 m_axi_awvalid/awready  out/in  1/1  write-address handshake.
REQ-012 m_axi_awaddr  out  64  write address.
REQ-013 m_axi_awlen  out  8  burst length; always 0.
REQ-014 m_axi_awid  out  AXI_IDWIDTH  equals CFG_ID.
REQ-015 m_axi_wvalid/wready  out/in  1/1  write-data handshake.
REQ-016 m_axi_wdata  out  64  write data.
REQ-017 m_axi_wlast  out  1  high whenever wvalid is high.
REQ-018 m_axi_bvalid/bready  in/out  1/1  write-response handshake.
REQ-019 m_axi_bid  in  AXI_IDWIDTH  response ID; ignored.
REQ-020 m_axi_bresp  in  2  write response.
REQ-021 init_data_finish  out  1  configuration complete; drives chacha20.init_data_finish.
REQ-022 busy  out  1  programming in progress.
REQ-023 err  out  1  sticky error flag, set by a non-OKAY bresp.

Function
REQ-024 SHALL latch key, counter and nonce on an accepted start; inputs are don't-care afterwards.
REQ-025 SHALL accept start only in IDLE or DONE; start while busy is ignored.
REQ-026 SHALL write six single-beat bursts, beat b = 0..5, each to awaddr = 0x10*b.
- Beats 0..3 carry wdata = {k(2b+1), k(2b)}.
- Beat 4 carries {n0, counter}.
- Beat 5 carries {n2, n1}.
REQ-027 SHALL use FSM states IDLE, AW, W, B, DONE.
- IDLE -start-> AW.
- AW -awready-> W.
- W -wready-> B.
- B -bvalid & OKAY & b<5-> AW with b+1.
- B -bvalid & OKAY & b=5-> DONE.
- B -bvalid & non-OKAY-> IDLE with err=1.
- DONE -start-> AW with b=0.
REQ-028 SHALL hold valid and payload stable until the matching ready is seen.
- awvalid is high only in AW; wvalid/wlast only in W; bready only in B.
- AW and W are never asserted in the same cycle.
REQ-029 awvalid SHALL rise in the cycle after start is sampled.
- With a zero-wait slave (bvalid in the cycle after the W handshake), each beat takes exactly 3 cycles.
- init_data_finish rises in the cycle after the 6th B handshake: 19 cycles after start.
REQ-030 init_data_finish SHALL be high only in DONE and SHALL fall in the cycle after an accepted start.
REQ-031 busy SHALL be high in AW, W and B.
REQ-032 err SHALL clear only on an accepted start or on reset.

Reset
REQ-033 On areset SHALL go to IDLE with b=0 and the latched key, counter and nonce cleared.
REQ-034 On areset SHALL drive all valid/ready outputs, awaddr, wdata, wlast, init_data_finish, busy and err to 0.
REQ-035 Reset mid-transaction SHALL abandon the burst with no further beats; the next start reprograms all six beats.

Configuration
REQ-036 Macro CHACHA_AUTO_REKEY_EN defined: in DONE, a rising edge of outdate_key SHALL increment the latched counter by 1 (0xFFFFFFFF wraps to 0), drop init_data_finish and reprogram all six beats as on start.
REQ-037 Macro CHACHA_AUTO_REKEY_EN undefined: outdate_key SHALL be ignored, and no rekey occurs without start.

Verification
REQ-038 Zero-wait slave, start with RFC 7539 key (k0=0x03020100 … k7=0x1f1e1d1c), counter=1, nonce n1=0x4a000000 -> six beats in order:
- 0x00 data 0x0706050403020100.
- 0x40 data 0x0000000000000001.
- 0x50 data 0x000000004a000000.
- init_data_finish rises 19 cycles after start.
REQ-039 awready and wready held low 5 cycles on beat 2 -> awaddr/wdata stable throughout, no AW/W overlap, completion delayed by exactly 10 cycles.
REQ-040 bresp=2'b10 on beat 3 -> err=1, busy=0, init_data_finish=0, no beat 4 issued; a following start clears err.
REQ-041 areset pulsed while in W of beat 1 -> all outputs 0 next cycle; a subsequent start begins at 0x00.
REQ-042 Start pulsed during beat 2 -> ignored, and beat data keeps the original latched values.
REQ-043 Macro defined, counter=0xFFFFFFFF, outdate_key rises in DONE -> reprogramming occurs with beat 4 data 0x0000000000000000; macro undefined -> no AXI activity.

Source files
------------

// File: rtl/chacha20_cfg_loader_if.sv
// AXI4 write-only channel bundle used by the ChaCha20 config loader.
// master = loader side, slave = memory-mapped core side.
interface chacha20_cfg_loader_if #(
  parameter int AXI_IDWIDTH = 4
);
  logic                   awvalid;
  logic                   awready;
  logic [63:0]            awaddr;
  logic [7:0]             awlen;
  logic [AXI_IDWIDTH-1:0] awid;
  logic                   wvalid;
  logic                   wready;
  logic [63:0]            wdata;
  logic                   wlast;
  logic                   bvalid;
  logic                   bready;
  logic [AXI_IDWIDTH-1:0] bid;
  logic [1:0]             bresp;

  modport master (
    output awvalid, awaddr, awlen, awid,
    input  awready,
    output wvalid, wdata, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awid,
    output awready,
    input  wvalid, wdata, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/chacha20_cfg_loader.sv
// Programs ChaCha20 key/counter/nonce as six single-beat AXI4 writes.
// Optional CHACHA_AUTO_REKEY_EN: bump counter and reprogram on outdate_key.
module chacha20_cfg_loader #(
  parameter int AXI_IDWIDTH = 4,
  parameter int CFG_ID      = 0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
  input  logic [255:0]                 key,
  input  logic [31:0]                  counter,
  input  logic [95:0]                  nonce,
  input  logic                         outdate_key,
  chacha20_cfg_loader_if.master        m_axi,
  output logic                         init_data_finish,
  output logic                         busy,
  output logic                         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [2:0]     beat_q;
  logic [2:0]     beat_d;
  logic [255:0]   key_q;
  logic [31:0]    ctr_q;
  logic [95:0]    nonce_q;
  logic           err_q;
  logic           accept;
  logic           rekey;
  logic           set_err;
  logic           rekey_req;
  logic [63:0]    beat_data;

`ifdef CHACHA_AUTO_REKEY_EN
  logic okey_q;

  always_ff @(posedge aclk) begin
    if (areset) okey_q <= 1'b0;
    else        okey_q <= outdate_key;
  end

  assign rekey_req = outdate_key & ~okey_q;
`else
  logic unused_okey;
  assign unused_okey = outdate_key;
  assign rekey_req   = 1'b0;
`endif

  logic unused_bid;
  assign unused_bid = ^m_axi.bid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      key_q   <= '0;
      ctr_q   <= '0;
      nonce_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        key_q   <= key;
        ctr_q   <= counter;
        nonce_q <= nonce;
      end else if (rekey) begin
        ctr_q   <= ctr_q + 32'd1;
      end
      if (accept)       err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    rekey   = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          beat_d  = '0;
          state_d = S_AW;
        end
      end
      S_AW: if (m_axi.awready) state_d = S_W;
      S_W:  if (m_axi.wready)  state_d = S_B;
      S_B: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            set_err = 1'b1;
            state_d = S_IDLE;
          end else if (beat_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = S_AW;
          end
        end
      end
      S_DONE: begin
        // an explicit start wins over a simultaneous rekey edge
        if (start) begin
          accept  = 1'b1;
          beat_d  = '0;
          state_d = S_AW;
        end else if (rekey_req) begin
          rekey   = 1'b1;
          beat_d  = '0;
          state_d = S_AW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (beat_q)
      3'd0:    beat_data = key_q[63:0];
      3'd1:    beat_data = key_q[127:64];
      3'd2:    beat_data = key_q[191:128];
      3'd3:    beat_data = key_q[255:192];
      3'd4:    beat_data = {nonce_q[31:0], ctr_q};
      default: beat_data = nonce_q[95:32];
    endcase
  end

  assign m_axi.awvalid   = (state_q == S_AW);
  assign m_axi.awaddr    = {57'd0, beat_q, 4'd0};
  assign m_axi.awlen     = 8'd0;
  assign m_axi.awid      = AXI_IDWIDTH'(CFG_ID);
  assign m_axi.wvalid    = (state_q == S_W);
  assign m_axi.wlast     = (state_q == S_W);
  assign m_axi.wdata     = beat_data;
  assign m_axi.bready    = (state_q == S_B);
  assign init_data_finish = (state_q == S_DONE);
  assign busy            = (state_q == S_AW) |
                           (state_q == S_W)  |
                           (state_q == S_B);
  assign err             = err_q;

endmodule

// File: tb/tb_chacha20_cfg_loader.sv
// Directed bench for chacha20_cfg_loader with a small AXI write slave.
// Slave stalls / error beats are selected per scenario.
module tb_chacha20_cfg_loader;
  localparam int IDW = 4;
  localparam int CID = 5;

  localparam logic [255:0] RFC_KEY =
    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [95:0] RFC_NONCE = 96'h00000000_4a000000_00000000;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [31:0]  counter = '0;
  logic [95:0]  nonce = '0;
  logic         outdate_key = 1'b0;
  logic         idf;
  logic         busy;
  logic         err;

  int total = 0;
  int bad = 0;

  int stall_beat = -1;
  int fail_beat = -1;
  int aw_cnt = 0;
  int w_cnt = 0;
  int overlap = 0;
  int unstable = 0;
  int hdr_bad = 0;
  logic        aw_hold = 1'b0;
  logic        w_hold = 1'b0;
  logic [63:0] aw_hold_val = '0;
  logic [63:0] w_hold_val = '0;
  logic [63:0] aw_log[$];
  logic [63:0] w_log[$];
  logic [63:0] exp_rfc[6];

  chacha20_cfg_loader_if #(.AXI_IDWIDTH(IDW)) m ();

  chacha20_cfg_loader #(
    .AXI_IDWIDTH(IDW),
    .CFG_ID(CID)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .start(start),
    .key(key),
    .counter(counter),
    .nonce(nonce),
    .outdate_key(outdate_key),
    .m_axi(m.master),
    .init_data_finish(idf),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  assign m.awready = m.awvalid &&
    (stall_beat != int'(m.awaddr[7:4]) || aw_cnt >= 5);
  assign m.wready = m.wvalid &&
    (stall_beat != int'(m.awaddr[7:4]) || w_cnt >= 5);
  assign m.bvalid = m.bready;
  assign m.bresp = (fail_beat == int'(m.awaddr[7:4])) ? 2'b10 : 2'b00;
  assign m.bid = '0;

  always @(posedge clk) begin
    if (m.awvalid && !m.awready) aw_cnt <= aw_cnt + 1;
    else aw_cnt <= 0;
    if (m.wvalid && !m.wready) w_cnt <= w_cnt + 1;
    else w_cnt <= 0;
    if (m.awvalid && m.wvalid) overlap <= overlap + 1;
    if (m.awvalid && m.awready) begin
      aw_log.push_back(m.awaddr);
      if (m.awlen !== 8'd0 || m.awid !== IDW'(CID))
        hdr_bad <= hdr_bad + 1;
    end
    if (m.wvalid && m.wready) begin
      w_log.push_back(m.wdata);
      if (m.wlast !== 1'b1) hdr_bad <= hdr_bad + 1;
    end
    if (aw_hold && m.awvalid && m.awaddr !== aw_hold_val)
      unstable <= unstable + 1;
    if (w_hold && m.wvalid && m.wdata !== w_hold_val)
      unstable <= unstable + 1;
    aw_hold <= m.awvalid && !m.awready;
    aw_hold_val <= m.awaddr;
    w_hold <= m.wvalid && !m.wready;
    w_hold_val <= m.wdata;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idf(output int n);
    n = 1;
    while (!idf && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({m.awvalid, m.wvalid, m.wlast, m.bready, idf, busy, err,
         m.awaddr, m.wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b idf=%b busy=%b err=%b",
               m.awvalid, m.wvalid, m.bready, idf, busy, err);
    end
    areset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_rfc();
    int n;
    key = RFC_KEY;
    counter = 32'd1;
    nonce = RFC_NONCE;
    clear_logs();
    pulse_start();
    total++;
    if (m.awvalid !== 1'b1) begin
      bad++;
      $display("FAIL rfc_aw_first got=%b want=1", m.awvalid);
    end
    key = '1;
    counter = 32'hdead_beef;
    nonce = '1;
    wait_idf(n);
    total++;
    if (n !== 19) begin
      bad++;
      $display("FAIL rfc_latency got=%0d want=19", n);
    end
    total++;
    if (aw_log.size() !== 6 || w_log.size() !== 6) begin
      bad++;
      $display("FAIL rfc_beats got aw=%0d w=%0d want=6",
               aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (aw_log[i] !== 64'(16 * i) || w_log[i] !== exp_rfc[i]) begin
          bad++;
          $display("FAIL rfc_beat%0d got addr=%h data=%h want addr=%h data=%h",
                   i, aw_log[i], w_log[i], 64'(16 * i), exp_rfc[i]);
        end
      end
    end
    total++;
    if (hdr_bad !== 0 || overlap !== 0) begin
      bad++;
      $display("FAIL rfc_hdr got hdr_bad=%0d overlap=%0d want=0",
               hdr_bad, overlap);
    end
  endtask

  task automatic test_stall();
    int n;
    key = RFC_KEY;
    counter = 32'd1;
    nonce = RFC_NONCE;
    stall_beat = 2;
    clear_logs();
    pulse_start();
    wait_idf(n);
    stall_beat = -1;
    total++;
    if (n !== 29) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=29", n);
    end
    total++;
    if (unstable !== 0 || overlap !== 0) begin
      bad++;
      $display("FAIL stall_stable got unstable=%0d overlap=%0d want=0",
               unstable, overlap);
    end
    total++;
    if (w_log.size() !== 6 || w_log[2] !== exp_rfc[2]) begin
      bad++;
      $display("FAIL stall_data got n=%0d want beat2=%h",
               w_log.size(), exp_rfc[2]);
    end
  endtask

  task automatic test_error();
    int k;
    int n;
    key = RFC_KEY;
    counter = 32'd1;
    nonce = RFC_NONCE;
    fail_beat = 3;
    clear_logs();
    pulse_start();
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || idf !== 1'b0) begin
      bad++;
      $display("FAIL err_flags got err=%b busy=%b idf=%b want 1 0 0",
               err, busy, idf);
    end
    repeat (5) @(negedge clk);
    total++;
    if (aw_log.size() !== 4 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_no_beat4 got beats=%0d err=%b want 4 1",
               aw_log.size(), err);
    end
    fail_beat = -1;
    pulse_start();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    wait_idf(n);
    total++;
    if (n !== 19) begin
      bad++;
      $display("FAIL err_recover got=%0d want=19", n);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int n;
    key = RFC_KEY;
    counter = 32'd1;
    nonce = RFC_NONCE;
    pulse_start();
    k = 0;
    while (!(m.wvalid && m.awaddr == 64'h10) && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 50) begin
      bad++;
      $display("FAIL rstmid_reach got timeout want W beat1");
    end
    areset = 1'b1;
    @(negedge clk);
    total++;
    if ({m.awvalid, m.wvalid, m.wlast, m.bready, idf, busy, err,
         m.awaddr, m.wdata} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got aw=%b w=%b addr=%h data=%h busy=%b",
               m.awvalid, m.wvalid, m.awaddr, m.wdata, busy);
    end
    areset = 1'b0;
    clear_logs();
    repeat (5) @(negedge clk);
    total++;
    if (aw_log.size() !== 0) begin
      bad++;
      $display("FAIL rstmid_quiet got beats=%0d want=0", aw_log.size());
    end
    pulse_start();
    wait_idf(n);
    total++;
    if (n !== 19 || aw_log.size() !== 6 || aw_log[0] !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_restart got n=%0d beats=%0d want 19 6 from 0",
               n, aw_log.size());
    end
  endtask

  task automatic test_start_busy();
    int k;
    int n;
    key = RFC_KEY;
    counter = 32'd1;
    nonce = RFC_NONCE;
    clear_logs();
    pulse_start();
    key = '1;
    counter = 32'd7;
    nonce = '1;
    k = 0;
    while (!(busy && m.awaddr == 64'h20) && k < 50) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idf(n);
    total++;
    if (w_log.size() !== 6) begin
      bad++;
      $display("FAIL busy_start_beats got=%0d want=6", w_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (w_log[i] !== exp_rfc[i]) begin
          bad++;
          $display("FAIL busy_start_beat%0d got=%h want=%h",
                   i, w_log[i], exp_rfc[i]);
        end
      end
    end
  endtask

  task automatic test_rekey();
    int n;
    key = RFC_KEY;
    counter = 32'hffff_ffff;
    nonce = RFC_NONCE;
    clear_logs();
    pulse_start();
    wait_idf(n);
    total++;
    if (w_log.size() !== 6 || w_log[4] !== 64'h00000000_ffffffff) begin
      bad++;
      $display("FAIL rekey_base got n=%0d want beat4=00000000ffffffff",
               w_log.size());
    end
    clear_logs();
    @(negedge clk);
    outdate_key = 1'b1;
`ifdef CHACHA_AUTO_REKEY_EN
    @(negedge clk);
    total++;
    if (idf !== 1'b0 || m.awvalid !== 1'b1) begin
      bad++;
      $display("FAIL rekey_drop got idf=%b aw=%b want 0 1", idf, m.awvalid);
    end
    wait_idf(n);
    total++;
    if (w_log.size() !== 6 || w_log[4] !== 64'h0 ||
        w_log[0] !== exp_rfc[0]) begin
      bad++;
      $display("FAIL rekey_data got n=%0d want beat4=0", w_log.size());
    end
`else
    repeat (30) @(negedge clk);
    total++;
    if (aw_log.size() !== 0 || idf !== 1'b1) begin
      bad++;
      $display("FAIL rekey_ignored got beats=%0d idf=%b want 0 1",
               aw_log.size(), idf);
    end
`endif
    outdate_key = 1'b0;
  endtask

  initial begin
    exp_rfc[0] = 64'h07060504_03020100;
    exp_rfc[1] = 64'h0f0e0d0c_0b0a0908;
    exp_rfc[2] = 64'h17161514_13121110;
    exp_rfc[3] = 64'h1f1e1d1c_1b1a1918;
    exp_rfc[4] = 64'h00000000_00000001;
    exp_rfc[5] = 64'h00000000_4a000000;
    test_reset();
    test_rfc();
    test_stall();
    test_error();
    test_reset_mid();
    test_start_busy();
    test_rekey();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
